// File: rtl/t_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : t_pulse_gen
// Description : Burst generator of single-cycle toggle enables for a t_ff stage;
//               emits `count` pulses spaced `period` cycles apart, then `done`.
// Revision    : 1.0 - initial release
// ============================================================================
module t_pulse_gen #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] period,
    input  logic [CW-1:0] count,
    output logic          t,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulses_left
);

    localparam logic [PW-1:0] c_pe_one  = PW'(1);
    localparam logic [CW-1:0] c_rem_one = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_t;
    logic          w_t_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic [PW-1:0] r_div;
    logic [PW-1:0] w_div_nxt;
    logic [PW-1:0] r_pe;
    logic [PW-1:0] w_pe_nxt;
    logic [PW-1:0] w_pe_eff;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_rem_nxt;

    // A zero period would otherwise underflow the interval counter on load.
    assign w_pe_eff = (period == '0) ? c_pe_one : period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t     <= 1'b0;
            r_done  <= 1'b0;
            r_div   <= '0;
            r_pe    <= c_pe_one;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_done  <= w_done_nxt;
            r_div   <= w_div_nxt;
            r_pe    <= w_pe_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = 1'b0;
        w_done_nxt  = 1'b0;
        w_div_nxt   = r_div;
        w_pe_nxt    = r_pe;
        w_rem_nxt   = r_rem;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pe_nxt    = w_pe_eff;
                    w_div_nxt   = w_pe_eff - c_pe_one;
                    w_rem_nxt   = count;
                    w_state_nxt = (count == '0) ? S_LAST : S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_rem_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_div == '0) begin
                    w_t_nxt     = 1'b1;
                    w_div_nxt   = r_pe - c_pe_one;
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - c_rem_one;
                    end
                    w_state_nxt = (r_rem <= c_rem_one) ? S_LAST : S_RUN;
                end else begin
                    w_div_nxt = r_div - c_pe_one;
                end
            end
            S_LAST: begin
                // An abort during the final pulse cycle is not a completion.
                w_done_nxt  = ~stop;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign t           = r_t;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);
    assign pulses_left = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_t_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_pulse_gen
// Description : Scoreboard bench for t_pulse_gen with a behavioural t_ff load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_pulse_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] period;
    logic [7:0] count;
    logic       t;
    logic       busy;
    logic       done;
    logic [7:0] pulses_left;

    t_pulse_gen #(.PW(8), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .count       (count),
        .t           (t),
        .busy        (busy),
        .done        (done),
        .pulses_left (pulses_left)
    );

    typedef struct {
        int         edge_n;
        logic       t;
        logic       done;
        logic       busy;
        logic [7:0] pl;
    } ev_t;

    ev_t sb[$];
    int  edge_n  = 0;
    int  n_tot   = 0;
    int  n_pass  = 0;
    int  toggles = 0;
    logic q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Downstream toggle flip-flop driven by t.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q       <= ~q;
            toggles <= toggles + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    // Monitor: every cycle with t or done high must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (t || done)) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_event: t=%0b done=%0b at edge %0d, none expected", t, done, edge_n);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_edge", edge_n, e.edge_n);
                chk("ev_t", {31'd0, t}, {31'd0, e.t});
                chk("ev_done", {31'd0, done}, {31'd0, e.done});
                chk("ev_busy", {31'd0, busy}, {31'd0, e.busy});
                chk("ev_pulses_left", {24'd0, pulses_left}, {24'd0, e.pl});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int en, input logic et, input logic ed, input logic eb, input logic [7:0] pl);
        ev_t e;
        e.edge_n = en; e.t = et; e.done = ed; e.busy = eb; e.pl = pl;
        sb.push_back(e);
    endtask

    // Issues a start sampled at the next edge; optionally queues the full burst.
    task automatic burst(input logic [7:0] p, input logic [7:0] c, input bit do_push, output int k);
        int pe;
        pe = (p == 8'd0) ? 1 : int'(p);
        k  = edge_n + 1;
        if (do_push) begin
            for (int i = 1; i <= int'(c); i++)
                push_ev(k + i * pe, 1'b1, 1'b0, 1'b1, 8'(int'(c) - i));
            push_ev(k + int'(c) * pe + 1, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        period = p;
        count  = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !busy && !done) return;
            tick();
        end
        n_tot++;
        $display("FAIL timeout_%s: busy=%0b pending=%0d, required idle with none pending", name, busy, sb.size());
    endtask

    initial begin
        int k;
        int tg;
        rst = 1'b0; start = 1'b0; stop = 1'b0; period = 8'd0; count = 8'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_t", {31'd0, t}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pulses_left", {24'd0, pulses_left}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Nominal burst with downstream toggle count.
        tg = toggles;
        burst(8'd3, 8'd4, 1'b1, k);
        chk("nom_busy_start", {31'd0, busy}, 32'd1);
        wait_idle("nominal");
        tick();
        chk("nom_toggles", toggles - tg, 32'd4);
        chk("nom_q", {31'd0, q}, 32'd0);

        // Period 0 and period 1 produce the same continuous trace.
        burst(8'd0, 8'd3, 1'b1, k);
        wait_idle("period0");
        burst(8'd1, 8'd3, 1'b1, k);
        wait_idle("period1");

        // Zero-count burst.
        burst(8'd2, 8'd0, 1'b1, k);
        chk("zero_busy_k", {31'd0, busy}, 32'd1);
        chk("zero_t_k", {31'd0, t}, 32'd0);
        tick();
        chk("zero_busy_k1", {31'd0, busy}, 32'd0);
        chk("zero_done_k1", {31'd0, done}, 32'd1);
        wait_idle("zero");

        // Abort at the edge the second pulse would fire.
        burst(8'd4, 8'd5, 1'b0, k);
        push_ev(k + 4, 1'b1, 1'b0, 1'b1, 8'd4);
        while (edge_n < k + 7) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_t", {31'd0, t}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pulses_left", {24'd0, pulses_left}, 32'd0);
        repeat (6) tick();
        chk("abort_drained", sb.size(), 32'd0);

        // Start while busy is ignored.
        burst(8'd2, 8'd3, 1'b1, k);
        tick();
        period = 8'd5; count = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("busy_start");

        // Start+stop together in IDLE, then start in the done cycle.
        stop = 1'b1;
        burst(8'd1, 8'd2, 1'b1, k);
        stop = 1'b0;
        while (edge_n < k + 3) tick();
        chk("hs_done_cycle", {31'd0, done}, 32'd1);
        burst(8'd2, 8'd2, 1'b1, k);
        wait_idle("done_cycle_start");

        // Asynchronous reset mid-burst.
        burst(8'd3, 8'd4, 1'b1, k);
        while (edge_n < k + 5) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_pulses_left", {24'd0, pulses_left}, 32'd3);
        #3 rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_t", {31'd0, t}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_pulses_left", {24'd0, pulses_left}, 32'd0);
        tick();
        #2 rst = 1'b0;
        tg = toggles;
        repeat (20) tick();
        chk("post_rst_no_pulse", toggles - tg, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t_pulse_gen.md
# t_pulse_gen

Programmable toggle-enable generator that drives the `t` input of the `t_ff` toggle flip-flop stage directly downstream. On a `start` request it emits a burst of `count` single-cycle `t` pulses, spaced `period` clock cycles apart, then signals completion. This lets the downstream flip-flop toggle a known number of times at a known rate, for example as a clock divider or a parity/phase generator, without per-cycle control from the host logic.

## Interface
- `PW`, default 8: width of the `period` input and of the interval counter.
- `CW`, default 8: width of the `count` input and of the `pulses_left` output.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; takes effect immediately, independent of `clk`.
- `start`  in  1  burst request; sampled only in IDLE.
- `stop`  in  1  abort request; sampled only in RUN/LAST.
- `period`  in  PW  pulse spacing in cycles; latched at start; 0 is treated as 1.
- `count`  in  CW  number of `t` pulses in the burst; latched at start.
- `t`  out  1  registered toggle enable to `t_ff`; high for exactly one cycle per pulse.
- `busy`  out  1  high while a burst is in progress (state ≠ IDLE).
- `done`  out  1  registered one-cycle completion strobe.
- `pulses_left`  out  CW  number of pulses not yet emitted.

## Operation
- State machine:
  - **IDLE**: waiting for `start`.
  - **RUN**: counting down and emitting pulses.
  - **LAST**: occupies the cycle in which the final pulse is high, or the single cycle of a zero-count burst.
- Internal registers:
  - `div` (PW bits): interval down-counter.
  - `rem` (CW bits): pulses remaining; `pulses_left` = `rem`.
  - `pe` (PW bits): latched effective period, `pe` = (`period`==0) ? 1 : `period`.
- **IDLE** with `start`=1:
  - `pe` <= effective period; `div` <= `pe`−1; `rem` <= `count`.
  - Next state is RUN, or LAST if `count`==0 (in that case no pulse is emitted).
- **RUN**, each edge, evaluated in priority order:
  - `stop`=1: `t` <= 0; state <= IDLE; `rem` <= 0; `done` stays 0 (an abort is not a completion).
  - `div`==0: `t` <= 1; `div` <= `pe`−1; `rem` <= `rem`−1; state <= LAST if `rem`==1, otherwise RUN.
  - Otherwise: `t` <= 0; `div` <= `div`−1.
- **LAST**, each edge:
  - `t` <= 0; state <= IDLE.
  - `done` <= 1, unless `stop`=1 in LAST, which is an abort: `done` stays 0.
- `done` returns to 0 on the following edge unless it is set again.
- `start` while `busy`=1 (RUN or LAST) is ignored. `stop` in IDLE is ignored. If `start` and `stop` are both high in IDLE, `start` wins.
- Counters never wrap: `div` and `rem` are only decremented when nonzero.
- **Reset** (asynchronous, at any time, including mid-burst):
  - state = IDLE.
  - `t`=0, `busy`=0, `done`=0, `pulses_left`=0.
  - `div`=0, `pe`=1.
  - No pulse is emitted after reset deasserts until a new `start`.

## Timing
- `start` sampled at edge k: `busy`=1 from edge k.
- First `t` pulse is high in the cycle after edge k+`pe`.
- Subsequent pulses are exactly `pe` cycles apart, each one cycle wide.
- With `pe`=1, `t` is high continuously for `count` cycles.
- Last pulse high after edge k+`count`·`pe`. At the next edge, `busy`=0 and `done`=1 for one cycle.
- `count`=0: `busy` high for one cycle (after edge k); `done` high after edge k+1; `t` stays 0.
- A new `start` is accepted in the same cycle `done` is high, because state is IDLE. Back-to-back bursts therefore have one idle cycle between them.
- `stop` sampled at edge j: `t`=0 and `busy`=0 after edge j; a pulse scheduled for edge j is suppressed.
- `pulses_left` updates on the same edge that raises `t`.

## Test plan
- Reset mid-burst:
  - Stimulus: `period`=3, `count`=4, `start` at edge 2; assert `rst` asynchronously between edges 7 and 8.
  - Required: outputs go to 0 immediately, before the next edge; no `t` pulse after `rst` falls.
- Nominal burst:
  - Stimulus: `period`=3, `count`=4, `start` at edge 2.
  - Required: `t` high after edges 5, 8, 11, 14; `pulses_left` reads 3, 2, 1, 0; `busy` falls and `done`=1 after edge 15; downstream `t_ff` `q` toggles 4 times, returning to 0.
- Period 0 / 1 equivalence:
  - Stimulus: `period`=0, `count`=3.
  - Required: `t` high for 3 consecutive cycles, then `done`. Repeat with `period`=1 and check the trace is identical.
- Zero count:
  - Stimulus: `count`=0, `start` at edge k.
  - Required: `t` never high; `busy` high for one cycle; `done` after edge k+1.
- Abort:
  - Stimulus: `period`=4, `count`=5, `stop` at the edge a second pulse would fire.
  - Required: that pulse is suppressed; `busy`=0; `done` never asserts; `pulses_left`=0.
- Handshake edges:
  - Stimulus: `start` re-asserted while `busy` with new `period`/`count`; then `start`+`stop` together in IDLE; then `start` in the `done` cycle.
  - Required: the in-busy `start` is ignored (the original burst completes unchanged); the simultaneous `start`+`stop` starts a burst; the `start` in the `done` cycle starts the next burst.
